// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: decides advance / stall / flush each cycle and
// provides run, single-step and halt-and-drain control plus bring-up counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | paused after reset or when run drops; pipeline frozen
// RUN     | free-running; hazards and HALT handled each cycle
// STEP    | exactly one advancing cycle, then back to IDLE or HALTED
// DRAIN   | HALT seen; keep advancing so in-flight instructions retire
// HALTED  | drained and frozen; only step or reset leave
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int STALL_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rt,
  input  logic               branch_taken,
  input  logic               halt_instr,
  output logic               pc_write,
  output logic               pc_sel,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               pipe_en,
  output logic [2:0]         state,
  output logic [31:0]        cycle_count,
  output logic [STALL_W-1:0] stall_count
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t        cur_state, nxt_state;
  logic [DW-1:0] drain_cnt;
  logic          step_from_halt;
  logic          luh;
  logic          advancing;
  logic          load_use_stall;
  logic          halt_accept;

  assign luh = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign advancing = (cur_state == S_RUN) || (cur_state == S_STEP) ||
                     (cur_state == S_DRAIN);

  always_comb begin
    pc_write       = 1'b0;
    pc_sel         = 1'b0;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    pipe_en        = 1'b0;
    load_use_stall = 1'b0;
    halt_accept    = 1'b0;
    nxt_state      = cur_state;

    if (advancing) begin
      pipe_en = 1'b1;
      if (cur_state == S_DRAIN) begin
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
      end else if (luh) begin
        idex_bubble    = 1'b1;
        load_use_stall = 1'b1;
      end else if (halt_instr) begin
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        halt_accept = 1'b1;
      end else if (branch_taken) begin
        pc_sel     = 1'b1;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end

    case (cur_state)
      S_IDLE: begin
        if (run)       nxt_state = S_RUN;
        else if (step) nxt_state = S_STEP;
      end
      // An accepted HALT has already left ID, so it wins over run dropping.
      S_RUN: begin
        if (halt_accept) nxt_state = S_DRAIN;
        else if (!run)   nxt_state = S_IDLE;
      end
      S_STEP: begin
        if (halt_accept)         nxt_state = S_DRAIN;
        else if (step_from_halt) nxt_state = S_HALTED;
        else                     nxt_state = S_IDLE;
      end
      S_DRAIN: begin
        if (drain_cnt == '0) nxt_state = S_HALTED;
      end
      S_HALTED: begin
        if (step) nxt_state = S_STEP;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state      <= S_IDLE;
      drain_cnt      <= '0;
      step_from_halt <= 1'b0;
      cycle_count    <= '0;
      stall_count    <= '0;
    end else begin
      cur_state <= nxt_state;
      if (halt_accept)
        drain_cnt <= DRAIN_LOAD;
      else if ((cur_state == S_DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - 1'b1;
      if (nxt_state == S_STEP)
        step_from_halt <= (cur_state == S_HALTED);
      if (pipe_en)
        cycle_count <= cycle_count + 32'd1;
      if (load_use_stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

  assign state = cur_state;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the MIPS-DLX pipeline. It decides each cycle whether the pipeline advances, stalls or flushes, and drives the enables and selects consumed by `instruction_fetch`, the IF/ID and ID/EX registers, and the downstream stage registers. It also provides run / single-step / halt-and-drain control and cycle/stall counters for bring-up.

## Interface

Parameters:
- `DRAIN_CYCLES`, 3: cycles the pipeline keeps advancing after a HALT leaves ID, so in-flight instructions retire.
- `STALL_W`, 16: stall counter width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  level; 1 = free-run, 0 = pause at the next cycle boundary.
- `step`  in  1  one-cycle pulse; advance exactly one cycle while paused or halted.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads `rt` as a source.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rt`  in  5  destination of the load in EX.
- `branch_taken`  in  1  branch/jump resolved taken in ID; same as `branch_sel_test`.
- `halt_instr`  in  1  ID holds a HALT instruction.
- `pc_write`  out  1  PC load enable.
- `pc_sel`  out  1  drives `PC_sel`; 1 = load `jump_address`.
- `ifid_write`  out  1  IF/ID register load enable.
- `ifid_flush`  out  1  IF/ID loads a NOP instead of the fetched word.
- `idex_bubble`  out  1  ID/EX loads zero control (`EX/M/WB_control = 0`).
- `pipe_en`  out  1  enable for ID/EX and all later stage registers.
- `state`  out  3  encoded FSM state.
- `cycle_count`  out  32  cycles with `pipe_en = 1`; wraps.
- `stall_count`  out  `STALL_W`  load-use stall cycles; saturates at all-ones.

## Operation

FSM states, encoded on `state`: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- IDLE: entered on reset. `run` → RUN; `step` → STEP.
- RUN: `run=0` → IDLE. HALT accepted → DRAIN. Otherwise stays in RUN.
- STEP: always lasts exactly one cycle. It returns to the state it came from (IDLE or HALTED). If a HALT is accepted during the step, the next state is DRAIN.
- DRAIN: an internal counter loads `DRAIN_CYCLES - 1` on entry and decrements each cycle. At 0 → HALTED. `run` and `step` are ignored.
- HALTED: `step` → STEP. `run` is ignored. Only reset returns to IDLE.

"Advancing" means state is RUN, STEP or DRAIN. Outputs are combinational from the state and current inputs (Mealy).
- Not advancing (IDLE, HALTED): all of `pc_write`, `ifid_write`, `ifid_flush`, `idex_bubble`, `pipe_en`, `pc_sel` are 0, so the whole pipeline freezes.
- Load-use hazard: `luh = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt))`.

Decisions while advancing, first match wins:
1. DRAIN: `pc_write=0`, `ifid_write=1`, `ifid_flush=1`, `pipe_en=1`.
2. `luh`: `pc_write=0`, `ifid_write=0`, `idex_bubble=1`, `pipe_en=1`, `pc_sel=0`. Load-use takes priority over `branch_taken` and `halt_instr`; the branch or HALT is re-evaluated after the stall.
3. `halt_instr`: `pc_write=0`, `ifid_flush=1`, `ifid_write=1`, `pipe_en=1`. The HALT proceeds to EX as a NOP-control bubble (`idex_bubble=1`). Enter DRAIN.
4. `branch_taken`: `pc_sel=1`, `pc_write=1`, `ifid_write=1`, `ifid_flush=1`, `pipe_en=1`.
5. Otherwise: `pc_write=1`, `ifid_write=1`, `pipe_en=1`, with `ifid_flush`, `idex_bubble` and `pc_sel` at 0.

Counters:
- `cycle_count` increments when `pipe_en=1`.
- `stall_count` increments on cycles where rule 2 fires, and saturates.

## Timing

- Reset takes effect at the clock edge with `reset=1`. Afterwards: state IDLE, both counters 0, drain counter 0, and all control outputs 0. `reset` overrides `run` and `step` in the same cycle, including mid-DRAIN.
- `run` rising in IDLE: the first `pipe_en=1` cycle is the cycle after the edge.
- `step` in IDLE/HALTED gives exactly one `pipe_en=1` cycle, the next cycle. A `step` held high for N cycles yields one step per two cycles (STEP, then IDLE/HALTED), not one per cycle.
- Load-use stall lasts one cycle. The next cycle `ex_mem_read` refers to the bubble, so `luh` drops.
- HALT accepted in cycle T: DRAIN covers T+1..T+DRAIN_CYCLES, and HALTED is entered at T+DRAIN_CYCLES+1.
- `cycle_count` wraps from 0xFFFFFFFF to 0.

## Test plan

- Reset with `run=1`, then release: `state=0` and all control outputs 0 during reset; one cycle after release `state=1`, `pc_write=pipe_en=1`.
- RUN, `ex_mem_read=1`, `ex_rt=5`, `id_rs=5`, `branch_taken=1` → one cycle of `pc_write=0`, `ifid_write=0`, `idex_bubble=1`, `pc_sel=0`; `stall_count` goes 0→1. Repeat with `ex_rt=0` → no stall.
- RUN, `branch_taken=1`, no hazard → `pc_sel=1`, `ifid_flush=1` for exactly that cycle.
- RUN, `halt_instr=1` at T with `DRAIN_CYCLES=3` → `pc_write=0` from T onward; `pipe_en=1` through T+3; `state=4` and all outputs 0 at T+4; `cycle_count` frozen afterwards.
- HALTED, pulse `step` three times spaced 3 cycles apart → `cycle_count` rises by exactly 3, one per step; `run=1` has no effect.
- Assert `reset` at the second DRAIN cycle → IDLE next cycle, counters 0.
